// File: rtl/vga_capture_if.sv
// ---------------------------------------------------------------------------
// vga_capture_if
//   Bundle between a VGA-timed pixel source and the capture block.
//   Video side : i_hsync, i_vsync (active low), i_red/i_green/i_blue (8 bit)
//   Write side : o_wr_en strobe, o_wr_addr, o_wr_data {r,g,b}
//   Status     : o_locked, o_frame_done, o_err
//   Modports   : slave  -> the capture block (consumes video, drives writes)
//                master -> the video source / frame-buffer side
//   ADDR_W must match the ADDR_W of the capture block bound to it.
// ---------------------------------------------------------------------------
interface vga_capture_if #(
  parameter int ADDR_W = 19
);
  logic              i_hsync;
  logic              i_vsync;
  logic [7:0]        i_red;
  logic [7:0]        i_green;
  logic [7:0]        i_blue;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [23:0]       o_wr_data;
  logic              o_locked;
  logic              o_frame_done;
  logic              o_err;

  modport slave (
    input  i_hsync, i_vsync, i_red, i_green, i_blue,
    output o_wr_en, o_wr_addr, o_wr_data, o_locked, o_frame_done, o_err
  );

  modport master (
    output i_hsync, i_vsync, i_red, i_green, i_blue,
    input  o_wr_en, o_wr_addr, o_wr_data, o_locked, o_frame_done, o_err
  );
endinterface

// File: rtl/vga_capture.sv
// ---------------------------------------------------------------------------
// vga_capture
//   Receive side of the frame-buffer VGA path. Registers the incoming VGA
//   stream, recovers the pixel position from the sync falling edges, checks
//   line/frame lengths, locks after LOCK_FRAMES good frames and then emits
//   one sequential frame-buffer write per active (optionally decimated) pixel.
//   Ports:
//     clk25MHz - pixel clock
//     rst      - synchronous active-high reset
//     bus      - vga_capture_if.slave (video in, write requests/status out)
//   Latency: o_wr_* lags the video pins by exactly two rising edges.
// ---------------------------------------------------------------------------
module vga_capture #(
  parameter int RES_X        = 640,
  parameter int RES_Y        = 480,
  parameter int H_PIXELS     = 800,
  parameter int V_PIXELS     = 525,
  parameter int RTRN_HSYNC   = 96,
  parameter int H_BACK_PORCH = 48,
  parameter int RTRN_VSYNC   = 2,
  parameter int V_BACK_PORCH = 33,
  parameter int RES_DIV      = 1,
  parameter int ADDR_W       = 19,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic          clk25MHz,
  input  logic          rst,
  vga_capture_if.slave  bus
);

  localparam int H_ST   = RTRN_HSYNC + H_BACK_PORCH;
  localparam int V_ST   = RTRN_VSYNC + V_BACK_PORCH;
  localparam int GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [11:0] H_MAX      = 12'hFFF;
  localparam logic [10:0] V_MAX      = 11'h7FF;
  localparam logic [11:0] H_ST_C     = 12'(H_ST);
  localparam logic [11:0] H_END_C    = 12'(H_ST + RES_X);
  localparam logic [10:0] V_ST_C     = 11'(V_ST);
  localparam logic [10:0] V_END_C    = 11'(V_ST + RES_Y);
  localparam logic [12:0] H_LEN_C    = 13'(H_PIXELS);
  localparam logic [11:0] V_LEN_C    = 12'(V_PIXELS);
  localparam logic [11:0] H_DIV_MASK = 12'(RES_DIV - 1);
  localparam logic [10:0] V_DIV_MASK = 11'(RES_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'((RES_X / RES_DIV) * (RES_Y / RES_DIV) - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_e;

  // Stage 1 input registers and their previous values for edge detection
  logic        hs1_q, vs1_q, hs_prev_q, vs_prev_q;
  logic [23:0] pix1_q;

  // Position / reference tracking
  logic [11:0]       h_cnt_q, h_cnt_d;
  logic [10:0]       v_cnt_q, v_cnt_d;
  logic              h_ref_q, h_ref_d, v_ref_q, v_ref_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;

  // Control
  state_e            state_q;
  logic [GOOD_W-1:0] good_q;

  // Output registers
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [23:0]       wr_data_q;
  logic              locked_q, frame_done_q, err_q;

  // Combinational decode
  logic        hs_fall, vs_fall;
  logic        line_bad, frame_bad, h_sat_now, mismatch;
  logic        active, decim_ok;
  logic [11:0] h_off;
  logic [10:0] v_off;

  // h_cnt_d / v_cnt_d are the coordinates of the pixel currently sitting in
  // stage 1, so the write decision made here is registered at the next edge.
  // NOTE: every signal written in always_comb gets a value on every path
  // (here by unconditional assignment); a missed path infers a latch.
  always_comb begin
    hs_fall = hs_prev_q & ~hs1_q;
    vs_fall = vs_prev_q & ~vs1_q;

    if (hs_fall)               h_cnt_d = '0;
    else if (h_cnt_q == H_MAX) h_cnt_d = H_MAX;
    else                       h_cnt_d = h_cnt_q + 12'd1;

    // vsync has priority when both edges land in the same cycle
    if (vs_fall)                          v_cnt_d = '0;
    else if (hs_fall && v_cnt_q != V_MAX) v_cnt_d = v_cnt_q + 11'd1;
    else                                  v_cnt_d = v_cnt_q;

    // Lengths are only checked against a reference edge seen earlier
    line_bad  = hs_fall && h_ref_q && (({1'b0, h_cnt_q} + 13'd1) != H_LEN_C);
    frame_bad = vs_fall && v_ref_q && (({1'b0, v_cnt_q} + 12'd1) != V_LEN_C);
    // Missing hsync: flag only the cycle the counter enters saturation
    h_sat_now = (h_cnt_d == H_MAX) && (h_cnt_q != H_MAX);
    mismatch  = line_bad | frame_bad | h_sat_now;

    if (mismatch)     h_ref_d = 1'b0;
    else if (hs_fall) h_ref_d = 1'b1;
    else              h_ref_d = h_ref_q;

    if (mismatch)     v_ref_d = 1'b0;
    else if (vs_fall) v_ref_d = 1'b1;
    else              v_ref_d = v_ref_q;

    active = (h_cnt_d >= H_ST_C) && (h_cnt_d < H_END_C) &&
             (v_cnt_d >= V_ST_C) && (v_cnt_d < V_END_C);

    // Power-of-two decimation: keep pixels whose offsets are multiples of
    // RES_DIV; the address just counts writes, so no multiplier is needed.
    h_off    = h_cnt_d - H_ST_C;
    v_off    = v_cnt_d - V_ST_C;
    decim_ok = ((h_off & H_DIV_MASK) == '0) && ((v_off & V_DIV_MASK) == '0);

    wr_en_d  = (state_q == LOCKED) && !mismatch && active && decim_ok;
    addr_cur = vs_fall ? '0 : addr_q;
    addr_d   = wr_en_d ? addr_cur + ADDR_W'(1) : addr_cur;
  end

  // Datapath: input stage, counters, write and frame-done registers.
  // NOTE: state uses non-blocking assignments so every register samples the
  // values from before the edge, independent of statement order.
  // NOTE: the pixel and write-data registers are reset too, because every
  // output must read 0 during reset, not only the control bits.
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      pix1_q       <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      h_ref_q      <= 1'b0;
      v_ref_q      <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hs1_q        <= bus.i_hsync;
      vs1_q        <= bus.i_vsync;
      hs_prev_q    <= hs1_q;
      vs_prev_q    <= vs1_q;
      pix1_q       <= {bus.i_red, bus.i_green, bus.i_blue};
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      h_ref_q      <= h_ref_d;
      v_ref_q      <= v_ref_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_q  <= addr_cur;
        wr_data_q  <= pix1_q;
      end
      frame_done_q <= wr_en_q && (wr_addr_q == LAST_ADDR) && (state_q == LOCKED);
    end
  end

  // Lock state machine with registered status outputs
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      state_q  <= HUNT;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        HUNT: begin
          if (vs_fall) begin
            state_q <= TRACK;
            good_q  <= '0;
          end
        end
        TRACK: begin
          if (mismatch) begin
            err_q   <= 1'b1;
            good_q  <= '0;
            state_q <= HUNT;
          end else if (vs_fall && v_ref_q) begin
            // Line errors already bounced us to HUNT, so a checked vsync
            // edge here means the whole frame was clean.
            good_q <= good_q + GOOD_W'(1);
            if (good_q == GOOD_LAST) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (mismatch) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            good_q   <= '0;
            state_q  <= HUNT;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_err        = err_q;

endmodule
